// File: rtl/fft_pkg.sv
// Shared types and widths for the FFT control blocks.
// State encoding is one-hot so each state decodes from a single flop.
package fft_pkg;

  localparam int FFT_LOG2N_MAX = 10;
  localparam int STAGE_W       = 4;
  localparam int CFG_W         = 4;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_LOAD = 5'b00010,
    ST_RUN  = 5'b00100,
    ST_GAP  = 5'b01000,
    ST_FIN  = 5'b10000
  } state_t;

endpackage

// File: rtl/fft_bf_sequencer_if.sv
// Butterfly descriptor channel between the sequencer and the butterfly datapath.
// The sequencer is the master; the datapath answers with bf_ready.
interface fft_bf_sequencer_if
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N_MAX
);

  logic               bf_valid;
  logic               bf_ready;
  logic [LOG2N-1:0]   top_idx;
  logic [LOG2N-1:0]   bot_idx;
  logic [LOG2N-2:0]   tw_idx;
  logic [STAGE_W-1:0] stage;
  logic               last_bf;

  modport master (
    output bf_valid, top_idx, bot_idx, tw_idx, stage, last_bf,
    input  bf_ready
  );

  modport slave (
    input  bf_valid, top_idx, bot_idx, tw_idx, stage, last_bf,
    output bf_ready
  );

endinterface

// File: rtl/fft_bf_index.sv
// Radix-2 DIT butterfly address generator: maps (butterfly k, stage s) to the
// in-place top/bottom sample indices and a twiddle index into a 2^LOG2N table.
module fft_bf_index
  import fft_pkg::*;
#(
  parameter int LOG2N = FFT_LOG2N_MAX
) (
  input  logic [LOG2N-2:0]   k,
  input  logic [STAGE_W-1:0] s,
  output logic [LOG2N-1:0]   top,
  output logic [LOG2N-1:0]   bot,
  output logic [LOG2N-2:0]   tw
);

  logic [LOG2N-1:0]   kx;
  logic [LOG2N-1:0]   half;
  logic [LOG2N-1:0]   j;
  logic [STAGE_W-1:0] tw_sh;

  always_comb begin
    kx    = {1'b0, k};
    half  = LOG2N'(1) << s;
    j     = kx & (half - LOG2N'(1));
    top   = ((kx >> s) << (s + STAGE_W'(1))) | j;
    bot   = top | half;
    // Scaling by the stage keeps one full-size twiddle ROM valid for every size.
    tw_sh = STAGE_W'(LOG2N - 1) - s;
    tw    = (LOG2N-1)'(j) << tw_sh;
  end

endmodule

// File: rtl/fft_bf_sequencer.sv
// Run-time sized radix-2 DIT FFT sequencer: walks stage/butterfly order and
// issues one index descriptor per handshake, with a drain gap between stages.
module fft_bf_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N     = FFT_LOG2N_MAX,
  parameter int STAGE_GAP = 4
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CFG_W-1:0]   cfg_log2n,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  fft_bf_sequencer_if.master bf
);

  localparam int KW = LOG2N - 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  state_t             state_reg;
  logic [CFG_W-1:0]   l_reg;
  logic [KW-1:0]      k_reg;
  logic [STAGE_W-1:0] s_reg;
  logic [GW-1:0]      gap_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;
  logic               valid_reg;

  logic [LOG2N-1:0]   top_reg;
  logic [LOG2N-1:0]   bot_reg;
  logic [KW-1:0]      tw_reg;
  logic [STAGE_W-1:0] stage_reg;
  logic               last_reg;

  logic [LOG2N-1:0]   half_n;
  logic [KW-1:0]      k_last;
  logic [STAGE_W-1:0] s_last;
  logic [KW-1:0]      idx_k;
  logic [STAGE_W-1:0] idx_s;
  logic [LOG2N-1:0]   idx_top;
  logic [LOG2N-1:0]   idx_bot;
  logic [KW-1:0]      idx_tw;
  logic               idx_last;
  logic               hs;
  logic               k_wrap;
  logic               last_stage;
  logic               load_desc;
  logic               cfg_bad;

  always_comb begin
    s_last     = l_reg - STAGE_W'(1);
    half_n     = LOG2N'(1) << s_last;
    k_last     = KW'(half_n - LOG2N'(1));
    hs         = valid_reg && bf.bf_ready;
    k_wrap     = (k_reg == k_last);
    last_stage = (s_reg == s_last);
    cfg_bad    = (cfg_log2n == '0) || (cfg_log2n > CFG_W'(LOG2N));

    // Counter values of the descriptor to be registered on this edge.
    idx_k = k_reg;
    idx_s = s_reg;
    if (state_reg == ST_RUN && hs) begin
      if (!k_wrap) begin
        idx_k = k_reg + KW'(1);
      end else if (!last_stage) begin
        idx_k = '0;
        idx_s = s_reg + STAGE_W'(1);
      end
    end
    idx_last = (idx_s == s_last) && (idx_k == k_last);

    load_desc = 1'b0;
    case (state_reg)
      ST_LOAD: load_desc = 1'b1;
      ST_RUN:  load_desc = hs && !(k_wrap && (last_stage || (STAGE_GAP > 0)));
      ST_GAP:  load_desc = (gap_reg == '0);
      default: load_desc = 1'b0;
    endcase
  end

  fft_bf_index #(
    .LOG2N (LOG2N)
  ) u_index (
    .k   (idx_k),
    .s   (idx_s),
    .top (idx_top),
    .bot (idx_bot),
    .tw  (idx_tw)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      l_reg     <= '0;
      k_reg     <= '0;
      s_reg     <= '0;
      gap_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            l_reg <= cfg_log2n;
            k_reg <= '0;
            s_reg <= '0;
            if (cfg_bad) begin
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
              state_reg <= ST_FIN;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          valid_reg <= 1'b1;
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (hs) begin
            k_reg <= idx_k;
            s_reg <= idx_s;
            if (k_wrap && last_stage) begin
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_FIN;
            end else if (k_wrap && (STAGE_GAP > 0)) begin
              valid_reg <= 1'b0;
              gap_reg   <= GW'(STAGE_GAP - 1);
              state_reg <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_reg == '0) begin
            valid_reg <= 1'b1;
            state_reg <= ST_RUN;
          end else begin
            gap_reg <= gap_reg - GW'(1);
          end
        end
        ST_FIN:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Descriptor register only moves on a load, so it holds through stalls.
  always_ff @(posedge Clk) begin
    if (reset) begin
      top_reg   <= '0;
      bot_reg   <= '0;
      tw_reg    <= '0;
      stage_reg <= '0;
      last_reg  <= 1'b0;
    end else if (load_desc) begin
      top_reg   <= idx_top;
      bot_reg   <= idx_bot;
      tw_reg    <= idx_tw;
      stage_reg <= idx_s;
      last_reg  <= idx_last;
    end else if (state_reg == ST_RUN && hs && k_wrap && last_stage) begin
      last_reg  <= 1'b0;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign cfg_err     = err_reg;
  assign bf.bf_valid = valid_reg;
  assign bf.top_idx  = top_reg;
  assign bf.bot_idx  = bot_reg;
  assign bf.tw_idx   = tw_reg;
  assign bf.stage    = stage_reg;
  assign bf.last_bf  = last_reg;

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Self-checking bench for fft_bf_sequencer: a group/butterfly-order FFT model
// feeds an expected-descriptor queue that is checked on every handshake.
module tb_fft_bf_sequencer;
  import fft_pkg::*;

  localparam int LOG2N     = 10;
  localparam int STAGE_GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cfg_log2n = 4'd0;
  logic       busy;
  logic       done;
  logic       cfg_err;

  fft_bf_sequencer_if #(.LOG2N(LOG2N)) bf ();

  fft_bf_sequencer #(
    .LOG2N     (LOG2N),
    .STAGE_GAP (STAGE_GAP)
  ) dut (
    .Clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_log2n (cfg_log2n),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .bf        (bf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int top;
    int bot;
    int tw;
    int stage;
    bit last;
    bit stage_end;
  } desc_t;

  desc_t exp_q[$];
  desc_t d_cmp;
  int    checks = 0;
  int    errors = 0;

  int  start_cyc = 0;
  int  exp_lat = -1;
  bit  exp_err = 0;
  bit  run_active = 0;
  bit  prev_stall = 0;
  bit  gap_pending = 0;
  int  gap_seen = 0;
  int  cur_stage = 0;
  bit  seen [0:(1<<LOG2N)-1];
  int  prev_top, prev_bot, prev_tw, prev_stage, prev_last;
  int  ready_mode = 0;
  int  stall_left = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Butterflies enumerated as stage -> group -> position within group.
  function automatic void build_model(input int L);
    exp_q.delete();
    foreach (seen[i]) seen[i] = 1'b0;
    cur_stage = 0;
    for (int s = 0; s < L; s++) begin
      int half;
      int span;
      int groups;
      half   = 1 << s;
      span   = 2 * half;
      groups = (1 << L) / span;
      for (int g = 0; g < groups; g++) begin
        for (int b = 0; b < half; b++) begin
          desc_t d;
          d.top       = g * span + b;
          d.bot       = d.top + half;
          d.tw        = b * ((1 << (LOG2N - 1)) / half);
          d.stage     = s;
          d.last      = (s == L - 1) && (g == groups - 1) && (b == half - 1);
          d.stage_end = (s < L - 1) && (g == groups - 1) && (b == half - 1);
          exp_q.push_back(d);
        end
      end
    end
  endfunction

  initial begin
    bf.bf_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: bf.bf_ready = ~bf.bf_ready;
        2: begin
          if (stall_left > 0) begin
            bf.bf_ready = 1'b0;
            stall_left--;
          end else if ($urandom_range(0, 4) == 0) begin
            bf.bf_ready = 1'b0;
            stall_left = 2;
          end else begin
            bf.bf_ready = 1'b1;
          end
        end
        default: bf.bf_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall  = 0;
      gap_pending = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", (bf.bf_valid && bf.top_idx == prev_top && bf.bot_idx == prev_bot &&
            bf.tw_idx == prev_tw && bf.stage == prev_stage && bf.last_bf == prev_last) ? 1 : 0, 1);
      if (gap_pending && bf.bf_valid) begin
        chk("gap_len", gap_seen, STAGE_GAP);
        gap_pending = 0;
      end else if (gap_pending) begin
        gap_seen++;
      end
      if (bf.bf_valid && bf.bf_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bf", 1, 0);
        end else begin
          d_cmp = exp_q.pop_front();
          chk("top_idx", bf.top_idx, d_cmp.top);
          chk("bot_idx", bf.bot_idx, d_cmp.bot);
          chk("tw_idx",  bf.tw_idx,  d_cmp.tw);
          chk("stage",   bf.stage,   d_cmp.stage);
          chk("last_bf", bf.last_bf, d_cmp.last);
          if (d_cmp.stage != cur_stage) begin
            foreach (seen[i]) seen[i] = 1'b0;
            cur_stage = d_cmp.stage;
          end
          chk("idx_unique", (seen[bf.top_idx] || seen[bf.bot_idx]) ? 1 : 0, 0);
          seen[bf.top_idx] = 1'b1;
          seen[bf.bot_idx] = 1'b1;
          if (d_cmp.stage_end) begin
            gap_pending = 1;
            gap_seen    = 0;
          end
        end
      end
      if (done) begin
        if (!run_active) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("done_queue_left", exp_q.size(), 0);
          chk("cfg_err", cfg_err, exp_err);
          chk("busy_at_done", busy, 0);
          if (exp_lat >= 0) chk("done_latency", cyc - start_cyc, exp_lat);
          run_active = 0;
        end
      end else begin
        chk("cfg_err_alone", cfg_err, 0);
        chk("busy", busy, (run_active && !exp_err && cyc > start_cyc) ? 1 : 0);
      end
      prev_stall = bf.bf_valid && !bf.bf_ready;
      prev_top   = bf.top_idx;
      prev_bot   = bf.bot_idx;
      prev_tw    = bf.tw_idx;
      prev_stage = bf.stage;
      prev_last  = bf.last_bf;
    end
  end

  task automatic do_start(input int L, input int lat, input bit err);
    @(posedge clk);
    #1;
    if (err) exp_q.delete();
    else build_model(L);
    exp_err    = err;
    exp_lat    = lat;
    start_cyc  = cyc;
    run_active = 1;
    start      = 1'b1;
    cfg_log2n  = L[3:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (run_active && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", run_active, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, bf.bf_valid, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   cfg_err, 0);
    chk({tag, "_last"},  bf.last_bf, 0);
    chk({tag, "_top"},   bf.top_idx, 0);
    chk({tag, "_bot"},   bf.bot_idx, 0);
    chk({tag, "_tw"},    bf.tw_idx, 0);
    chk({tag, "_stage"}, bf.stage, 0);
  endtask

  int lit_top [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_bot [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_tw  [12] = '{0, 0, 0, 0, 0, 256, 0, 256, 0, 128, 256, 384};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Pin the model against the hand-derived 8-point table.
    build_model(3);
    chk("model_len3", exp_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk("model_top", exp_q[i].top, lit_top[i]);
      chk("model_bot", exp_q[i].bot, lit_bot[i]);
      chk("model_tw",  exp_q[i].tw,  lit_tw[i]);
      chk("model_last", exp_q[i].last, (i == 11) ? 1 : 0);
    end
    build_model(10);
    chk("model_len10", exp_q.size(), 5120);
    exp_q.delete();

    // Done lands on cycle 2+N+gaps+1 counting the start cycle as 1, i.e. lat = 2+N+gaps.
    ready_mode = 0;
    do_start(3, 22, 0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    cfg_log2n = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(200);

    ready_mode = 1;
    do_start(3, -1, 0);
    wait_idle(400);

    ready_mode = 2;
    do_start(3, -1, 0);
    wait_idle(600);

    ready_mode = 0;
    do_start(10, 5158, 0);
    wait_idle(6000);

    do_start(0, 1, 1);
    wait_idle(20);
    do_start(11, 1, 1);
    wait_idle(20);

    // Abort a 16-point run partway through stage 1.
    do_start(4, -1, 0);
    n = 0;
    while (!(bf.bf_valid && bf.stage == 4'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_stage1", bf.stage, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_active = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("abort");
    repeat (30) @(posedge clk);

    do_start(1, 3, 0);
    wait_idle(50);

    // Start coincident with reset must be dropped.
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    cfg_log2n = 4'd3;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_start_busy", busy, 0);
    chk("rst_start_valid", bf.bf_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bf_sequencer.md
Name: fft_bf_sequencer

Overview:
- Parametrised radix-2 decimation-in-time FFT control sequencer; successor of the fixed 1024-point FFT control FSM.
- Walks every stage/group/butterfly of an in-place FFT whose size is chosen at run time (2^cfg_log2n ≤ 2^LOG2N).
- For each butterfly it emits the top/bottom RAM indices and the twiddle-ROM index over a valid/ready handshake.
- Sits between the sample-buffer controller (start/done) and the butterfly datapath/RAM arbiter; inserts a programmable drain gap between stages so in-place read-after-write hazards are impossible.

Parameters:
- LOG2N, 10, log2 of maximum FFT size; index width = LOG2N, twiddle width = LOG2N-1.
- STAGE_GAP, 4, idle cycles (bf_valid=0) inserted after the last accepted butterfly of each stage except the final one; 0 allowed.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform; sampled only in IDLE.
- cfg_log2n  in  4  log2 of transform size, latched on accepted start; legal range 1..LOG2N.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of transform (also on config error).
- cfg_err  out  1  one-cycle pulse coincident with done when cfg_log2n was illegal.
- bf_valid  out  1  butterfly descriptor valid.
- bf_ready  in  1  datapath accepts descriptor when bf_valid&&bf_ready.
- top_idx  out  LOG2N  top-branch sample index.
- bot_idx  out  LOG2N  bottom-branch sample index (= top_idx + half).
- tw_idx  out  LOG2N-1  twiddle index into a 2^LOG2N-point table.
- stage  out  4  current stage s, 0..cfg_log2n-1.
- last_bf  out  1  high with the final descriptor of the whole transform.

Behaviour:
- Reset: state IDLE; busy, done, cfg_err, bf_valid, last_bf = 0; top_idx, bot_idx, tw_idx, stage = 0. Reset overrides start in the same cycle. Reset mid-transform aborts immediately with no done pulse; the next start runs normally.
- States (one-hot): IDLE, LOAD, RUN, GAP, FIN.
- IDLE: on start, latch L=cfg_log2n, clear butterfly counter k and stage s. L==0 or L>LOG2N → FIN with cfg_err set; otherwise → LOAD.
- LOAD: register first descriptor; busy=1. First bf_valid appears 2 cycles after the start edge.
- RUN: bf_valid=1. Descriptor registered; held stable while bf_valid && !bf_ready. On a handshake:
  - k < 2^(L-1)-1: k+1, next descriptor presented the next cycle (one descriptor per cycle under continuous ready).
  - k wraps and s < L-1: s+1, k=0; go to GAP if STAGE_GAP>0, else stay in RUN.
  - k wraps and s = L-1: → FIN.
- GAP: bf_valid=0 for exactly STAGE_GAP cycles (down-counter), then RUN with the stage's first descriptor.
- FIN: done=1 (cfg_err as latched) for one cycle, busy=0 in same cycle, bf_valid=0; → IDLE.
- start while not IDLE is ignored (no queueing).
- Index arithmetic, with half=2^s and j = k & (half-1):
  - top = ((k >> s) << (s+1)) | j
  - bot = top | half
  - tw = j << (LOG2N-1-s), so the same ROM serves all sizes.
  - All unsigned; no overflow is possible within LOG2N bits.
- last_bf = (s==L-1) && (k==2^(L-1)-1), registered with its descriptor.
- Total handshakes per transform = L·2^(L-1). Minimum cycles with ready tied high = 2 + L·2^(L-1) + (L-1)·STAGE_GAP + 1.

Decomposition:
- Shared package fft_pkg: FFT_LOG2N_MAX default, one-hot state localparams, descriptor field widths.
- One combinational sub-module fft_bf_index (inputs k, s; outputs top, bot, tw), reused later by the bit-reverse loader.
- Counters, FSM and output registers live in fft_bf_sequencer.

Test Plan:
- LOG2N=10, cfg=3, ready=1 → 12 descriptors (top,bot,tw):
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,256) (4,6,0) (5,7,256)
  - stage 2: (0,4,0) (1,5,128) (2,6,256) (3,7,384)
  - Exactly 4 gap cycles between stages; last_bf only on (3,7,384); done 1 cycle later.
- Same run with bf_ready toggling 1010… and random 3-cycle stalls → identical descriptor sequence; outputs never change while valid && !ready.
- cfg=10, ready=1 → 5120 handshakes, done at cycle 2+5120+36+1 after start; every index pair unique within each stage.
- cfg=0 and cfg=11 → no bf_valid; done and cfg_err pulse together 2 cycles after start; busy stays low.
- reset asserted during stage 1 of a cfg=4 run → next cycle all outputs 0, no done; subsequent start with cfg=1 → single descriptor (0,1,0) with last_bf=1, then done.
- start pulsed while busy, and start coincident with reset → both ignored; the transform in flight completes unchanged.
